// File: rtl/adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
// Optional build macro used by this block: PIPELINED_ADDER_OVERFLOW_EN.
package adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   // Number of pipeline stages needed to cover a width-bit add in chunk-bit slices.
   function automatic int n_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder assembled from 1-bit full-adder cells.
// With PIPELINED_ADDER_OVERFLOW_EN defined it also exports the carry into its MSB,
// which the top uses for signed overflow detection on the last chunk.
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
   ,
   output logic             c_msb
`endif
);

   // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk
   logic [CHUNK:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      // one full-adder cell per bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[CHUNK];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
   assign c_msb = carry[CHUNK-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: each stage adds one CHUNK-bit slice and registers
// its carry for the next stage. Unconsumed operand bits travel down the pipe
// with the result (skew) and finished low sum chunks are carried along (deskew),
// so the full sum and carry emerge together after STAGES cycles.
// A single advance signal stalls every stage when the output is held.
// Optional build macro: PIPELINED_ADDER_OVERFLOW_EN adds a registered signed
// overflow output aligned with sum.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int STAGES = n_stages(WIDTH, CHUNK);

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
   end

   logic             advance;

   // stage registers, index k holds the state after stage k
   logic             vld_p   [STAGES];
   logic             cy_p    [STAGES];
   logic [WIDTH-1:0] a_p     [STAGES];
   logic [WIDTH-1:0] b_p     [STAGES];
   logic [WIDTH-1:0] sum_p   [STAGES];

   // inputs seen by each stage and its combinational results
   logic             vld_src [STAGES];
   logic             ci_src  [STAGES];
   logic [WIDTH-1:0] a_src   [STAGES];
   logic [WIDTH-1:0] b_src   [STAGES];
   logic [WIDTH-1:0] sum_src [STAGES];
   logic [WIDTH-1:0] sum_nxt [STAGES];
   logic [CHUNK-1:0] ch_sum  [STAGES];
   logic             ch_cy   [STAGES];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
   logic             ch_msb  [STAGES];
   logic             ovf_p;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // stage 0 boundary: operands straight from the ports
         assign vld_src[k] = in_valid;
         assign ci_src[k]  = c_in;
         assign a_src[k]   = a;
         assign b_src[k]   = b;
         assign sum_src[k] = '0;
      end else begin : g_next
         // stage k boundary: everything comes from stage k-1 registers
         assign vld_src[k] = vld_p[k-1];
         assign ci_src[k]  = cy_p[k-1];
         assign a_src[k]   = a_p[k-1];
         assign b_src[k]   = b_p[k-1];
         assign sum_src[k] = sum_p[k-1];
      end

      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a     (a_src[k][k*CHUNK +: CHUNK]),
         .b     (b_src[k][k*CHUNK +: CHUNK]),
         .c_in  (ci_src[k]),
         .sum   (ch_sum[k]),
         .c_out (ch_cy[k])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
         ,
         .c_msb (ch_msb[k])
`endif
      );

      // slot this stage's chunk into the partially built sum (its slot is still zero)
      assign sum_nxt[k] = sum_src[k] | (WIDTH'(ch_sum[k]) << (k * CHUNK));
   end

   // The whole pipe moves when the output slot is empty or being consumed.
   assign advance   = !vld_p[STAGES-1] || out_ready;
   assign in_ready  = advance;

   // Stage registers: cleared by reset, otherwise loaded in lock-step on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k] <= 1'b0;
            cy_p[k]  <= 1'b0;
            a_p[k]   <= '0;
            b_p[k]   <= '0;
            sum_p[k] <= '0;
         end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
         ovf_p <= 1'b0;
`endif
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k] <= vld_src[k];
            cy_p[k]  <= ch_cy[k];
            a_p[k]   <= a_src[k];
            b_p[k]   <= b_src[k];
            sum_p[k] <= sum_nxt[k];
         end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
         // signed overflow: carry into MSB differs from carry out of MSB
         ovf_p <= ch_msb[STAGES-1] ^ ch_cy[STAGES-1];
`endif
      end
   end

   // output boundary: last stage drives the ports
   assign out_valid = vld_p[STAGES-1];
   assign sum       = sum_p[STAGES-1];
   assign c_out     = cy_p[STAGES-1];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
   assign overflow  = ovf_p;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks for pipelined_adder at WIDTH=16, CHUNK=4.
// Overflow checks are compiled in only with PIPELINED_ADDER_OVERFLOW_EN.
module tb_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              c_in;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  sum;
   logic              c_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
   logic              overflow;
`endif

   int checks = 0;
   int errors = 0;

   pipelined_adder #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ovf_now();
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      return overflow;
`else
      return 1'b0;
`endif
   endfunction

   // Present one operand set on an empty pipe, wait (bounded) for its result.
   task automatic send_one(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           output int lat, output logic [15:0] s, output logic co,
                           output logic ov);
      a = va; b = vb; c_in = vc; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         cycle();
         lat++;
      end
      s  = sum;
      co = c_out;
      ov = ovf_now();
      cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
      cycle();
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      checks++;
      if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b want 0", c_out); end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_directed();
      logic [15:0] va [10] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h000F,
                               16'h00FF, 16'h0FFF, 16'hFFFF, 16'hABCD, 16'h0000};
      logic [15:0] vb [10] = '{16'h0001, 16'h0001, 16'h4321, 16'h8000, 16'h0001,
                               16'h0000, 16'hF000, 16'hFFFF, 16'h1111, 16'h0000};
      logic        vc [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [15:0] es [10] = '{16'h0000, 16'h8000, 16'h5556, 16'h0000, 16'h0010,
                               16'h0100, 16'h0000, 16'hFFFF, 16'hBCDE, 16'h0000};
      logic        ec [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        eo [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      int          lat;
      logic [15:0] s;
      logic        co;
      logic        ov;
      for (int i = 0; i < 10; i++) begin
         send_one(va[i], vb[i], vc[i], lat, s, co, ov);
         checks++;
         if (lat != STAGES) begin errors++; $display("FAIL latency[%0d] got %0d want %0d", i, lat, STAGES); end
         checks++;
         if (s !== es[i]) begin errors++; $display("FAIL sum[%0d] got %h want %h", i, s, es[i]); end
         checks++;
         if (co !== ec[i]) begin errors++; $display("FAIL c_out[%0d] got %b want %b", i, co, ec[i]); end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
         checks++;
         if (ov !== eo[i]) begin errors++; $display("FAIL overflow[%0d] got %b want %b", i, ov, eo[i]); end
`else
         if (eo[i] === 1'b1 && ov === 1'b1) $display("note: unexpected overflow value");
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [4] = '{16'h0001, 16'hF0F0, 16'h1000, 16'h7FFF};
      logic [15:0] vb [4] = '{16'h0002, 16'h0F0F, 16'h2000, 16'h7FFF};
      logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [16:0] ex [4] = '{17'h00003, 17'h10000, 17'h03000, 17'h0FFFE};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i]; c_in = vc[i]; in_valid = 1'b1;
         cycle();
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", out_valid); end
      // stall with a junk operand offered; it must not be taken
      out_ready = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1; in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", j, in_ready); end
         checks++;
         if ({out_valid, c_out, sum} !== {1'b1, ex[0]}) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b %h want v=1 %h", j, out_valid, {c_out, sum}, ex[0]);
         end
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({out_valid, c_out, sum} !== {1'b1, ex[i]}) begin
            errors++;
            $display("FAIL b2b_result[%0d] got v=%b %h want v=1 %h", i, out_valid, {c_out, sum}, ex[i]);
         end
         cycle();
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra[%0d] got %b want 0", j, out_valid); end
         cycle();
      end
   endtask

   task automatic test_reset_flush();
      int          lat;
      logic [15:0] s;
      logic        co;
      logic        ov;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'h1111 * 16'(i + 1); b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
         cycle();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if ({out_valid, c_out, sum} !== 18'h0) begin
         errors++;
         $display("FAIL flush_cleared got v=%b c=%b s=%h want all 0", out_valid, c_out, sum);
      end
      for (int j = 0; j < 8; j++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got %b want 0", j, out_valid); end
      end
      send_one(16'h00FF, 16'h0F01, 1'b0, lat, s, co, ov);
      checks++;
      if (lat != STAGES) begin errors++; $display("FAIL flush_new_latency got %0d want %0d", lat, STAGES); end
      checks++;
      if ({co, s} !== 17'h01000) begin errors++; $display("FAIL flush_new_result got %h want 01000", {co, s}); end
   endtask

   task automatic test_throughput();
      logic [16:0] ex [20];
      int          idx;
      out_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         in_valid = (n < 20);
         a = 16'(n * 16'h0ABC);
         b = 16'(16'hFFFF - n * 3);
         c_in = n[0];
         if (n < 20) ex[n] = {1'b0, a} + {1'b0, b} + 17'(c_in);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_in_ready[%0d] got %b want 1", n, in_ready); end
         cycle();
         idx = n + 1 - STAGES;
         checks++;
         if (idx >= 0 && idx < 20) begin
            if ({out_valid, c_out, sum} !== {1'b1, ex[idx]}) begin
               errors++;
               $display("FAIL tput_result[%0d] got v=%b %h want v=1 %h", idx, out_valid, {c_out, sum}, ex[idx]);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tput_bubble[%0d] got %b want 0", n, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [16:0] q [$];
      logic [16:0] exp_r;
      logic [16:0] obs;
      logic [16:0] held;
      logic        acc;
      logic        del;
      logic        stalled;
      int          acc_n = 0;
      int          del_n = 0;
      int          cyc = 0;
      stalled = 1'b0;
      held = '0;
      while ((acc_n < 1000 && cyc < 6000) || (q.size() > 0 && cyc < 6100)) begin
         in_valid  = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
         out_ready = (acc_n >= 1000) || ($urandom_range(0, 3) != 0);
         a = 16'($urandom);
         b = 16'($urandom);
         c_in = 1'($urandom);
         #1;
         if (stalled) begin
            checks++;
            if ({out_valid, c_out, sum} !== {1'b1, held}) begin
               errors++;
               $display("FAIL rand_stall_stable got v=%b %h want v=1 %h", out_valid, {c_out, sum}, held);
            end
         end
         acc = in_valid && in_ready;
         del = out_valid && out_ready;
         obs = {c_out, sum};
         stalled = out_valid && !out_ready;
         held = obs;
         cycle();
         cyc++;
         if (del) begin
            del_n++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_unexpected got %h want no result", obs);
            end else begin
               exp_r = q.pop_front();
               if (obs !== exp_r) begin errors++; $display("FAIL rand_result[%0d] got %h want %h", del_n, obs, exp_r); end
            end
         end
         if (acc) begin
            q.push_back({1'b0, a} + {1'b0, b} + 17'(c_in));
            acc_n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (acc_n != 1000) begin errors++; $display("FAIL rand_accepted got %0d want 1000", acc_n); end
      checks++;
      if (del_n != acc_n) begin errors++; $display("FAIL rand_delivered got %0d want %0d", del_n, acc_n); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_flush();
      test_throughput();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and elaboration SHALL fail otherwise.
REQ-003 SHALL derive local constant STAGES = WIDTH/CHUNK, the pipeline depth.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the a, b and c_in operand set is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: the unsigned addends.
REQ-009 SHALL have port c_in, input, 1 bit: the carry into bit 0.
REQ-010 SHALL have port out_valid, output, 1 bit: sum and c_out hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: a + b + c_in, modulo 2^WIDTH.
REQ-013 SHALL have port c_out, output, 1 bit: the carry out of bit WIDTH-1.
REQ-014 SHALL have port overflow, output, 1 bit, present only per REQ-027: signed two's-complement overflow.

Function
REQ-015 Stage k (k = 0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of a and b plus the carry registered by stage k-1; stage 0 SHALL use c_in.
REQ-016 Operand chunks not yet consumed SHALL be delayed alongside the result, and completed lower sum chunks SHALL be carried forward with it (skew/deskew registers).
REQ-017 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid with the result, when out_ready is held high.
REQ-018 Throughput SHALL be one result per cycle with out_ready held high.
REQ-019 Each stage SHALL carry a valid bit; the global advance signal SHALL be advance = !out_valid || out_ready.
REQ-020 in_ready SHALL equal advance, combinationally.
REQ-021 While advance is 0, all stage registers SHALL hold, and sum, c_out and out_valid SHALL remain stable.
REQ-022 When advance is 1 and in_valid is 0, a bubble (valid = 0) SHALL enter stage 0.
REQ-023 Wrap-around: a result that exceeds 2^WIDTH - 1 SHALL wrap modulo 2^WIDTH, with c_out = 1.
REQ-024 Carry propagation SHALL be correct across every chunk boundary, including a full-length ripple (all-ones + 1).
REQ-025 Data outputs while out_valid = 0 are don't-care; verification SHALL NOT check them.

Reset
REQ-026 With rst high at a clock edge, every stage valid bit SHALL clear, and out_valid, sum, c_out and overflow SHALL be 0 the next cycle.
- Reset mid-operation SHALL discard all in-flight operations; none SHALL appear afterward.
- in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-027 Macro PIPELINED_ADDER_OVERFLOW_EN SHALL control the overflow feature.
- Defined: the overflow port SHALL exist and equal carry-into-MSB XOR c_out, aligned with sum and registered with the same latency.
- Undefined: the overflow port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package adder_pkg SHALL hold the default WIDTH and CHUNK constants and a stage-count function (WIDTH/CHUNK).
REQ-029 Sub-module adder_chunk SHALL be a combinational CHUNK-bit ripple adder, built from 1-bit full-adder cells, with ports a, b, c_in, sum, c_out (plus carry-into-MSB for overflow); it SHALL be instantiated once per stage.

Verification (WIDTH=16, CHUNK=4, STAGES=4)
REQ-030 Stimulus a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> exactly 4 cycles later: sum=0x0000, c_out=1.
REQ-031 Stimulus a=0x7FFF, b=0x0001, c_in=0 with the macro defined -> sum=0x8000, c_out=0, overflow=1; a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, overflow=0.
REQ-032 Stimulus of 4 back-to-back inputs, then out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable while stalled; all 4 results are delivered in order, none lost or duplicated.
REQ-033 Stimulus of rst asserted for one cycle with 3 operations in flight -> out_valid=0 from the next cycle; none of the 3 results ever appear; a new input then returns its result after 4 cycles.
REQ-034 Stimulus of 1000 random operand sets with random in_valid and out_ready -> a scoreboard matches (a+b+c_in) mod 2^16 and c_out for every result; with in_valid and out_ready held 1, exactly 1 result per cycle.
